// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux4_rr_arbiter : round-robin arbiter sharing one 4:1 W-bit mux channel
// Rev 1.0
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int W        = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  input  logic [W-1:0] I2,
  input  logic [W-1:0] I3,
  output logic [3:0]   gnt,
  output logic [1:0]   s,
  output logic [W-1:0] o,
  output logic         o_valid,
  output logic         expired
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t       r_state, w_state_nxt;
  logic [1:0]   r_ptr,   w_ptr_nxt;
  logic [7:0]   r_cnt,   w_cnt_nxt;
  logic [3:0]   r_gnt,   w_gnt_nxt;
  logic [1:0]   r_s,     w_s_nxt;
  logic [W-1:0] r_o,     w_o_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_exp,   w_exp_nxt;

  logic         w_any;
  logic [1:0]   w_win;
  logic [1:0]   w_scan;
  logic [1:0]   w_sel;
  logic [W-1:0] w_mux;

  // Scan from farthest to nearest offset so the nearest requester wins last
  always_comb begin
    w_any  = 1'b0;
    w_win  = r_ptr;
    w_scan = r_ptr;
    for (int j = 3; j >= 0; j--) begin
      w_scan = r_ptr + 2'(j);
      if (req[w_scan]) begin
        w_any = 1'b1;
        w_win = w_scan;
      end
    end
  end

  always_comb begin
    w_sel = (r_state == IDLE) ? w_win : r_s;
    case (w_sel)
      2'd0:    w_mux = I0;
      2'd1:    w_mux = I1;
      2'd2:    w_mux = I2;
      default: w_mux = I3;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_s_nxt     = r_s;
    w_o_nxt     = r_o;
    w_valid_nxt = r_valid;
    w_exp_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        if (w_any) begin
          w_gnt_nxt   = 4'b0001 << w_win;
          w_s_nxt     = w_win;
          w_o_nxt     = w_mux;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!req[r_s] || (r_cnt >= c_HOLD_LAST)) begin
          w_gnt_nxt   = 4'b0000;
          w_valid_nxt = 1'b0;
          w_exp_nxt   = req[r_s];
          w_ptr_nxt   = r_s + 2'd1;
          w_state_nxt = IDLE;
        end else begin
          w_o_nxt   = w_mux;
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= 8'd0;
      r_gnt   <= 4'b0000;
      r_s     <= 2'd0;
      r_o     <= '0;
      r_valid <= 1'b0;
      r_exp   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_s     <= w_s_nxt;
      r_o     <= w_o_nxt;
      r_valid <= w_valid_nxt;
      r_exp   <= w_exp_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign s       = r_s;
  assign o       = r_o;
  assign o_valid = r_valid;
  assign expired = r_exp;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter : directed bench, two instances (MAX_HOLD 8 and 2)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [4:0] I0, I1, I2, I3;

  logic [3:0] gnt     [2];
  logic [1:0] s       [2];
  logic [4:0] o       [2];
  logic       o_valid [2];
  logic       expired [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.W(5), .MAX_HOLD(8)) u_dut8 (
    .clk(clk), .rst(rst), .req(req), .I0(I0), .I1(I1), .I2(I2), .I3(I3),
    .gnt(gnt[0]), .s(s[0]), .o(o[0]), .o_valid(o_valid[0]), .expired(expired[0])
  );

  mux4_rr_arbiter #(.W(5), .MAX_HOLD(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req), .I0(I0), .I1(I1), .I2(I2), .I3(I3),
    .gnt(gnt[1]), .s(s[1]), .o(o[1]), .o_valid(o_valid[1]), .expired(expired[1])
  );

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %0h want %0h", nm, d, $time, act, exp);
    end
  endtask

  function automatic int din(input int k);
    case (k)
      0:       return int'(I0);
      1:       return int'(I1);
      2:       return int'(I2);
      default: return int'(I3);
    endcase
  endfunction

  // Model: owner index (-1 = none), cycles used in current grant, pointer
  int m_own [2], m_ptr [2], m_used [2], m_s [2], m_o [2], m_val [2], m_exp [2];
  int lim [2] = '{8, 2};
  bit m_live = 1'b0;

  always @(posedge clk) begin
    int w;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_own[d] = -1; m_ptr[d] = 0; m_used[d] = 0;
        m_s[d] = 0; m_o[d] = 0; m_val[d] = 0; m_exp[d] = 0;
      end else begin
        m_exp[d] = 0;
        if (m_own[d] < 0) begin
          m_val[d] = 0;
          for (int k = 0; k < 4; k++) begin
            w = (m_ptr[d] + k) % 4;
            if (req[w] && m_own[d] < 0) begin
              m_own[d] = w; m_s[d] = w; m_o[d] = din(w);
              m_val[d] = 1; m_used[d] = 1;
            end
          end
        end else if (!req[m_own[d]] || m_used[d] == lim[d]) begin
          m_exp[d] = req[m_own[d]] ? 1 : 0;
          m_ptr[d] = (m_own[d] + 1) % 4;
          m_own[d] = -1;
          m_val[d] = 0;
        end else begin
          m_used[d]++;
          m_o[d] = din(m_own[d]);
        end
      end
    end
    if (rst) m_live = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    if (m_live) begin
      for (int d = 0; d < 2; d++) begin
        chk("gnt",     d, int'(gnt[d]), (m_own[d] < 0) ? 0 : (1 << m_own[d]));
        chk("s",       d, int'(s[d]), m_s[d]);
        chk("o",       d, int'(o[d]), m_o[d]);
        chk("o_valid", d, int'(o_valid[d]), m_val[d]);
        chk("expired", d, int'(expired[d]), m_exp[d]);
      end
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000;
    I0 = 5'd1; I1 = 5'd2; I2 = 5'd3; I3 = 5'd4;
    edges(2);
    rst = 1'b0;
    repeat (5) begin
      edges(1);
      chk("lit_idle_gnt", 0, int'(gnt[0]), 0);
      chk("lit_idle_o",   0, int'(o[0]), 0);
      chk("lit_idle_vld", 0, int'(o_valid[0]), 0);
    end

    // single requester 2 for three cycles
    req = 4'b0100;
    edges(1);
    chk("lit_r2_gnt", 0, int'(gnt[0]), 4'b0100);
    chk("lit_r2_s",   0, int'(s[0]), 2);
    chk("lit_r2_o",   0, int'(o[0]), 3);
    chk("lit_r2_vld", 0, int'(o_valid[0]), 1);
    edges(2);
    chk("lit_r2_gnt3", 0, int'(gnt[0]), 4'b0100);
    req = 4'b0000;
    edges(1);
    chk("lit_rel_gnt",  0, int'(gnt[0]), 0);
    chk("lit_rel_vld",  0, int'(o_valid[0]), 0);
    chk("lit_rel_hold", 0, int'(o[0]), 3);

    // full rotation with MAX_HOLD=2
    rst = 1'b1; edges(1); rst = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 2; c++) begin
        edges(1);
        chk("lit_rot_gnt", 1, int'(gnt[1]), 1 << (g % 4));
        chk("lit_rot_o",   1, int'(o[1]), (g % 4) + 1);
      end
      edges(1);
      chk("lit_rot_gap", 1, int'(gnt[1]), 0);
      chk("lit_rot_exp", 1, int'(expired[1]), 1);
    end

    // operand change mid-grant
    req = 4'b0000; rst = 1'b1; edges(1); rst = 1'b0;
    req = 4'b0010;
    edges(1);
    chk("lit_i1_o0", 0, int'(o[0]), 2);
    I1 = 5'd9;
    edges(1);
    chk("lit_i1_o1", 0, int'(o[0]), 9);
    chk("lit_i1_s",  0, int'(s[0]), 1);
    req = 4'b0000; I1 = 5'd2;
    edges(2);

    // competing request while requester 0 holds
    rst = 1'b1; edges(1); rst = 1'b0;
    req = 4'b0001;
    edges(1);
    chk("lit_c_g0", 0, int'(gnt[0]), 4'b0001);
    req = 4'b1001;
    edges(1); chk("lit_c_g1", 0, int'(gnt[0]), 4'b0001);
    edges(1); chk("lit_c_g2", 0, int'(gnt[0]), 4'b0001);
    req = 4'b1000;
    edges(1); chk("lit_c_gap", 0, int'(gnt[0]), 0);
    edges(1); chk("lit_c_g3",  0, int'(gnt[0]), 4'b1000);

    // reset during a grant with cnt=4
    req = 4'b0000; rst = 1'b1; edges(1); rst = 1'b0;
    req = 4'b0100;
    edges(5);
    chk("lit_mr_pre", 0, int'(gnt[0]), 4'b0100);
    rst = 1'b1;
    edges(1);
    chk("lit_mr_gnt", 0, int'(gnt[0]), 0);
    chk("lit_mr_s",   0, int'(s[0]), 0);
    chk("lit_mr_o",   0, int'(o[0]), 0);
    chk("lit_mr_vld", 0, int'(o_valid[0]), 0);
    chk("lit_mr_exp", 0, int'(expired[0]), 0);
    rst = 1'b0; req = 4'b1111;
    edges(1);
    chk("lit_mr_first", 0, int'(gnt[0]), 4'b0001);
    edges(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
